delay_tap_reader: RTL
=====================

# delay_tap_reader

Programmable-latency data delay line built on a circular buffer. The write pointer is the existing modulo-DEPTH cycle counter, advancing on each enabled cycle. This block is the read side of that counter: each enabled cycle it stores one input word and returns the word stored `delay` enabled-cycles earlier. It is used in the ARM datapath to realign operands and control bits across pipeline stages of differing depth.

## Interface
Parameters:
- `DEPTH`, default 8: number of buffer slots, and the maximum delay. Any integer ≥ 2; it need not be a power of two.
- `WIDTH`, default 32: data word width.
- `AW`, localparam: `log2(DEPTH)` using the team's bit-count `log2`, so DEPTH=8 gives AW=4. It is wide enough to hold the value DEPTH.

Ports:
- `clk`, input, 1: the single clock. All state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `en`, input, 1: advance. When low, all state holds.
- `din`, input, WIDTH: word to store on an enabled edge.
- `delay`, input, AW: requested latency in enabled cycles. Legal range is 1..DEPTH.
- `dout`, output, WIDTH: registered delayed word.
- `dout_valid`, output, 1: registered. High when `dout` holds a genuinely delayed sample.

## Operation
- Effective delay `d`, combinational:
  - `delay` = 0 → d = 1.
  - `delay` > DEPTH → d = DEPTH.
  - otherwise d = `delay`.
- Write pointer `wp` runs 0..DEPTH-1 and wraps DEPTH-1 → 0. It advances only on edges where `en` is high.
- Fill count `fill` saturates at DEPTH. It counts the samples written since reset.
- Read address:
  - `wp >= d` → `rd = wp - d`.
  - otherwise → `rd = wp + DEPTH - d`.
  - Compute at AW+1 bits so there is no underflow.
- On each edge with `en` high:
  - `mem[wp] <= din`.
  - `dout_valid <= (fill >= d)`.
  - `dout <= (fill >= d) ? mem[rd] : 0`.
  - `wp` advances; `fill` increments unless it is already DEPTH.
- Read-before-write: when d = DEPTH, `rd == wp`. `dout` takes the old slot contents and `din` is not forwarded.
- With `en` low: `dout`, `dout_valid`, `wp`, `fill` and `mem` all hold.
- Changing `delay` mid-stream takes effect on the next enabled edge:
  - No flush is performed.
  - Validity is re-evaluated against `fill`, so raising `d` above `fill` drops `dout_valid`.
- The memory array is not reset. Its stale contents are never visible because `dout` is forced to 0 while invalid.

## Timing
- Reset values: `dout` = 0, `dout_valid` = 0, `wp` = 0, `fill` = 0. They take effect immediately on `rst` assertion, independent of `clk`.
- Reset mid-stream discards all buffered samples; the buffer refills from scratch.
- Latency: a sample accepted on enabled edge n appears on `dout` immediately after enabled edge n+d. Edges with `en` low do not count.
- First valid output: after enabled edge number d+1 counted from reset, with constant d. Example: d = 3 gives the first valid output on the 4th enabled edge.
- Simultaneous `rst` and `en`: reset wins.

## Structure
- Sub-module: the existing modulo counter (`Delay_Gen`, DW = DEPTH) instantiated as the write pointer, with `en` tied to this block's `en`.
  - Its cnt width is AW, which matches `wp`.
  - No new counter module is written.
- Shared package / include:
  - the team `log2` bit-count function;
  - a `clamp_delay` function (the d rule above), so the initiator-side and reader-side logic agree on legal delays.
- Remaining logic lives in this block: storage array, fill counter, read-address arithmetic, output registers.

## Test plan
- Basic fill, DEPTH=8, d=3: drive `din` = 1,2,3,… with `en` high continuously → `dout_valid` rises after the 4th edge with `dout`=1, then `dout` = 2,3,… one per edge.
- Maximum delay and wrap, d=8: run 20 enabled cycles → first valid output is `dout`=1 after edge 9; on every later edge `dout` = the `din` from 8 enabled edges earlier, including across `wp` wrapping 7 → 0. Also confirms `din` is never forwarded when `rd == wp`.
- Gaps in `en`, d=2: interleave `en` = 1,0,0,1,1,0,1 with `din` incremented only on enabled edges → latency counts enabled edges only; outputs hold while `en` = 0.
- Clamping, d=2 stream running: set `delay`=0 → behaves as d=1. Set `delay`=15 with DEPTH=8 → behaves as d=8, and `dout_valid` holds high because `fill` = 8.
- Delay change before full: after 3 enabled edges at d=2, set d=5 → `dout_valid` drops to 0 and `dout` = 0 until `fill` reaches 5; then the d=5 sequence resumes.
- Asynchronous reset mid-stream: assert `rst` between clock edges → `dout` = 0 and `dout_valid` = 0 immediately. After release, the first valid output takes the full d+1 enabled edges again, with no stale data.

Source files
------------

// File: rtl/delay_tap_reader_pkg.sv
// Shared helpers for the delay line: bit-count log2 and the legal-delay clamp.
// Both the initiator side and the reader side import this so they agree on d.
package delay_tap_reader_pkg;

    // Bit-count log2: the number of bits needed to hold the value itself (8 -> 4).
    function automatic int log2(input int value);
        int n;
        int v;
        n = 0;
        v = value;
        while (v > 0) begin
            n++;
            v = v >>> 1;
        end
        return n;
    endfunction

    function automatic int unsigned clamp_delay(input int unsigned delay, input int unsigned depth);
        if (delay == 0)
            return 1;
        if (delay > depth)
            return depth;
        return delay;
    endfunction

endpackage

// File: rtl/delay_tap_reader_delay_gen.sv
// Modulo-DW cycle counter used as the delay line's write pointer.
// Counts 0..DW-1 on enabled edges and wraps back to 0.
module Delay_Gen
    import delay_tap_reader_pkg::*;
#(
    parameter int DW = 8,
    localparam int CW = log2(DW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] cnt
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (en) begin
            if (r_cnt == CW'(DW - 1))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/delay_tap_reader.sv
// Read side of a circular-buffer delay line: stores din each enabled cycle and
// returns the word written d enabled cycles earlier, zeroed until enough history exists.
module delay_tap_reader
    import delay_tap_reader_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    localparam int AW = log2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    delay,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid
);

    // Index width for the storage array; AW is one bit wider to hold DEPTH itself.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]    w_wp;
    logic [AW-1:0]    w_d;
    logic [AW:0]      w_rd_ext;
    logic [IW-1:0]    w_rd;
    logic             w_ready;

    logic [AW-1:0]    r_fill;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic [WIDTH-1:0] r_mem [DEPTH];

    Delay_Gen #(.DW(DEPTH)) u_wp (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .cnt (w_wp)
    );

    assign w_d = AW'(clamp_delay(int'(delay), DEPTH));

    always_comb begin
        w_rd_ext = '0;
        if (w_wp >= w_d)
            w_rd_ext = {1'b0, w_wp} - {1'b0, w_d};
        else
            w_rd_ext = {1'b0, w_wp} + (AW + 1)'(DEPTH) - {1'b0, w_d};
        w_rd = w_rd_ext[IW-1:0];
    end

    assign w_ready = (r_fill >= w_d);

    // Storage is never reset; stale slots stay hidden because dout is zeroed while invalid.
    always_ff @(posedge clk) begin
        if (en)
            r_mem[w_wp[IW-1:0]] <= din;
    end

    // Read sees the old slot contents when rd == wp, so din is never forwarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_fill  <= '0;
        end else if (en) begin
            r_valid <= w_ready;
            r_dout  <= w_ready ? r_mem[w_rd] : '0;
            if (r_fill != AW'(DEPTH))
                r_fill <= r_fill + 1'b1;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_valid;

endmodule
